// File: rtl/fifo_read_port_pkg.sv
// Shared defaults and state encoding for the FIFO read-side controller.
// The optional statistics outputs are built only when FIFO_RD_STATS_EN is defined.
package fifo_read_port_pkg;

  localparam int NUM_BIT_DEF  = 4;
  localparam int NUM_REG_DEF  = 4;
  localparam int NUMP1_DEF    = NUM_REG_DEF + 1;
  localparam int PAR_READ_DEF = 2;
  localparam int PW_DEF       = $clog2(NUM_REG_DEF) + 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic [15:0] POP_MAX = 16'hFFFF;

endpackage

// File: rtl/ring_addr_add.sv
// Combinational (a+b) mod NUMP1 on PW-bit ring pointers; both operands must be < NUMP1.
module ring_addr_add
  import fifo_read_port_pkg::*;
#(
  parameter int NUMP1 = NUMP1_DEF,
  parameter int PW    = PW_DEF
) (
  input  logic [PW-1:0] a_i,
  input  logic [PW-1:0] b_i,
  output logic [PW-1:0] sum_o
);

  // One guard bit keeps the raw sum exact before the single conditional wrap.
  logic [PW:0] raw;
  logic [PW:0] wrapped;

  assign raw     = {1'b0, a_i} + {1'b0, b_i};
  assign wrapped = raw - (PW+1)'(NUMP1);
  assign sum_o   = (raw >= (PW+1)'(NUMP1)) ? wrapped[PW-1:0] : raw[PW-1:0];

endmodule

// File: rtl/fifo_read_port.sv
// Read-side controller of the circular multi-word FIFO: owns rd_ptr, fetches PAR_READ words
// per transfer into an output stage. Optional stats outputs under FIFO_RD_STATS_EN.
module fifo_read_port
  import fifo_read_port_pkg::*;
#(
  parameter  int NUM_BIT  = NUM_BIT_DEF,
  parameter  int NUM_REG  = NUM_REG_DEF,
  parameter  int NUMP1    = NUMP1_DEF,
  parameter  int PAR_READ = PAR_READ_DEF,
  localparam int PW       = $clog2(NUM_REG) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        init,
  input  logic [PW-1:0]               wr_ptr,
  output logic [PAR_READ*PW-1:0]      rd_addr,
  input  logic [PAR_READ*NUM_BIT-1:0] mem_rdata,
  output logic [PW-1:0]               rd_ptr,
  output logic [PW-1:0]               occupancy,
  output logic                        empty,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [PAR_READ*NUM_BIT-1:0] dout_data
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [15:0]                 pop_count,
  output logic [0:0]                  underrun
`endif
);

  state_e                      state_q, state_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_nxt;
  logic [PAR_READ*NUM_BIT-1:0] data_q;
  logic [PW:0]                 occ_raw;
  logic                        can_load;
  logic                        load;
  logic                        hs;

  // Per-slice read addresses wrap independently around the ring.
  for (genvar i = 0; i < PAR_READ; i++) begin : g_addr
    ring_addr_add #(.NUMP1(NUMP1), .PW(PW)) u_addr (
      .a_i   (rd_ptr_q),
      .b_i   (PW'(i)),
      .sum_o (rd_addr[i*PW +: PW])
    );
  end

  ring_addr_add #(.NUMP1(NUMP1), .PW(PW)) u_nxt (
    .a_i   (rd_ptr_q),
    .b_i   (PW'(PAR_READ)),
    .sum_o (rd_ptr_nxt)
  );

  always_comb begin
    if (wr_ptr >= rd_ptr_q) occ_raw = {1'b0, wr_ptr} - {1'b0, rd_ptr_q};
    else                    occ_raw = {1'b0, wr_ptr} - {1'b0, rd_ptr_q} + (PW+1)'(NUMP1);
  end

  assign occupancy  = occ_raw[PW-1:0];
  assign empty      = (occ_raw == '0);
  assign can_load   = (occ_raw >= (PW+1)'(PAR_READ));
  assign dout_valid = (state_q == ST_FULL);
  assign hs         = dout_valid && dout_ready;
  assign rd_ptr     = rd_ptr_q;
  assign dout_data  = data_q;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (can_load) begin
          load    = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (dout_ready) begin
          if (can_load) load    = 1'b1;
          else          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // The writer is cleared by the same init, so any pending pop is discarded.
    if (init) begin
      state_d = ST_EMPTY;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      rd_ptr_q <= '0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (init) begin
        rd_ptr_q <= '0;
      end else if (load) begin
        rd_ptr_q <= rd_ptr_nxt;
        data_q   <= mem_rdata;
      end
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [15:0] pop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        pop_q <= '0;
    else if (init)                   pop_q <= '0;
    else if (hs && pop_q != POP_MAX) pop_q <= pop_q + 16'd1;
  end

  assign pop_count = pop_q;
  assign underrun  = dout_ready && !dout_valid && empty;
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

`ifdef ASSERT
  always_ff @(posedge clk) begin
    if (rst && (wr_ptr >= PW'(NUMP1)))
      $error("fifo_read_port: wr_ptr %0d out of ring range", wr_ptr);
  end
`endif

endmodule

// File: tb/tb_fifo_read_port.sv
// Self-checking bench for fifo_read_port: directed scenarios plus randomized traffic
// checked against a ring-arithmetic reference model.
module tb_fifo_read_port;

  logic       clk;
  logic       rst;
  logic       init;
  logic [2:0] wr_ptr;
  logic [5:0] rd_addr;
  logic [7:0] mem_rdata;
  logic [2:0] rd_ptr;
  logic [2:0] occupancy;
  logic       empty;
  logic       dout_valid;
  logic       dout_ready;
  logic [7:0] dout_data;
`ifdef FIFO_RD_STATS_EN
  logic [15:0] pop_count;
  logic [0:0]  underrun;
`endif

  int total, bad;

  logic [3:0] mem [5];

  // Reference model state
  int         m_rd;
  logic       m_valid;
  logic [7:0] m_data;
  int         m_pop;

  fifo_read_port #(.NUM_BIT(4), .NUM_REG(4), .NUMP1(5), .PAR_READ(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .wr_ptr     (wr_ptr),
    .rd_addr    (rd_addr),
    .mem_rdata  (mem_rdata),
    .rd_ptr     (rd_ptr),
    .occupancy  (occupancy),
    .empty      (empty),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data)
`ifdef FIFO_RD_STATS_EN
    ,
    .pop_count  (pop_count),
    .underrun   (underrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: combinational read at each address slice.
  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 2; i++)
      if (rd_addr[i*3 +: 3] < 3'd5) mem_rdata[i*4 +: 4] = mem[rd_addr[i*3 +: 3]];
  end

  function automatic int m_occ();
    return (int'(wr_ptr) - m_rd + 5) % 5;
  endfunction

  // Advance the model by one edge using the pre-edge inputs, then step the clock.
  task automatic tick();
    int  occ;
    logic hs;
    occ = m_occ();
    hs  = m_valid && dout_ready;
    if (init) begin
      m_rd = 0; m_valid = 1'b0; m_pop = 0;
    end else begin
      if (hs && m_pop < 65535) m_pop++;
      if ((!m_valid || dout_ready) && occ >= 2) begin
        m_data  = {mem[(m_rd + 1) % 5], mem[m_rd]};
        m_rd    = (m_rd + 2) % 5;
        m_valid = 1'b1;
      end else if (hs) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++; if (rd_ptr !== 3'd0) begin bad++; $display("FAIL reset_rd_ptr got=%0d exp=0", rd_ptr); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    total++; if (dout_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", dout_data); end
    total++; if (empty !== 1'b1 || occupancy !== 3'd0) begin
      bad++; $display("FAIL reset_occ got empty=%b occ=%0d exp empty=1 occ=0", empty, occupancy); end
    m_rd = 0; m_valid = 1'b0; m_data = 8'h00; m_pop = 0;
  endtask

  task automatic test_fill();
    wr_ptr = 3'd1; #1;
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL fill_occ1 got=%0d exp=1", occupancy); end
    tick();
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL fill_partial_valid got=%b exp=0", dout_valid); end
    wr_ptr = 3'd2;
    tick();
    total++; if (dout_valid !== 1'b1 || dout_data !== 8'h98) begin
      bad++; $display("FAIL fill_data got v=%b d=%h exp v=1 d=98", dout_valid, dout_data); end
    total++; if (rd_ptr !== 3'd2 || occupancy !== 3'd0) begin
      bad++; $display("FAIL fill_ptr got rd=%0d occ=%0d exp rd=2 occ=0", rd_ptr, occupancy); end
  endtask

  task automatic test_backpressure();
    dout_ready = 1'b0;
    wr_ptr = 3'd3; tick();
    wr_ptr = 3'd4; tick();
    tick();
    total++; if (dout_data !== 8'h98 || rd_ptr !== 3'd2 || dout_valid !== 1'b1) begin
      bad++; $display("FAIL bp_hold got d=%h rd=%0d v=%b exp d=98 rd=2 v=1", dout_data, rd_ptr, dout_valid); end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    total++; if (dout_data !== 8'hBA || rd_ptr !== 3'd4 || dout_valid !== 1'b1) begin
      bad++; $display("FAIL bp_reload got d=%h rd=%0d v=%b exp d=BA rd=4 v=1", dout_data, rd_ptr, dout_valid); end
  endtask

  task automatic test_wrap();
    wr_ptr = 3'd1; #1;
    total++; if (rd_addr !== {3'd0, 3'd4} || occupancy !== 3'd2) begin
      bad++; $display("FAIL wrap_addr got addr=%b occ=%0d exp addr=000100 occ=2", rd_addr, occupancy); end
    dout_ready = 1'b1;
    tick();
    total++; if (dout_data !== 8'h8C || rd_ptr !== 3'd1 || dout_valid !== 1'b1) begin
      bad++; $display("FAIL wrap_fetch got d=%h rd=%0d v=%b exp d=8C rd=1 v=1", dout_data, rd_ptr, dout_valid); end
  endtask

  task automatic test_drain();
    wr_ptr = 3'd2;
    tick();
    total++; if (dout_valid !== 1'b0 || rd_ptr !== 3'd1 || dout_data !== 8'h8C) begin
      bad++; $display("FAIL drain got v=%b rd=%0d d=%h exp v=0 rd=1 d=8C", dout_valid, rd_ptr, dout_data); end
  endtask

  task automatic test_init_collision();
    dout_ready = 1'b0;
    wr_ptr = 3'd3;
    tick();
    total++; if (dout_valid !== 1'b1 || dout_data !== 8'hA9 || rd_ptr !== 3'd3) begin
      bad++; $display("FAIL init_pre got v=%b d=%h rd=%0d exp v=1 d=A9 rd=3", dout_valid, dout_data, rd_ptr); end
    wr_ptr = 3'd0; dout_ready = 1'b1; init = 1'b1; #1;
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL init_occ got=%0d exp=2", occupancy); end
    tick();
    init = 1'b0; dout_ready = 1'b0; #1;
    total++; if (rd_ptr !== 3'd0 || dout_valid !== 1'b0 || empty !== 1'b1) begin
      bad++; $display("FAIL init_clear got rd=%0d v=%b e=%b exp rd=0 v=0 e=1", rd_ptr, dout_valid, empty); end
`ifdef FIFO_RD_STATS_EN
    total++; if (pop_count !== 16'd0) begin bad++; $display("FAIL init_pop got=%0d exp=0", pop_count); end
`endif
  endtask

  task automatic test_random();
    int n, free;
    for (int c = 0; c < 400; c++) begin
      dout_ready = ($urandom_range(0, 3) != 0);
      init       = ($urandom_range(0, 63) == 0);
      free = 4 - m_occ();
      n = (free > 0) ? $urandom_range(0, free) : 0;
      for (int j = 0; j < n; j++) begin
        mem[(int'(wr_ptr)) % 5] = 4'($urandom);
        wr_ptr = 3'((int'(wr_ptr) + 1) % 5);
      end
      #1;
      total++; if (occupancy !== 3'(m_occ()) || empty !== (m_occ() == 0)) begin
        bad++; $display("FAIL rnd_occ c=%0d got occ=%0d e=%b exp occ=%0d", c, occupancy, empty, m_occ()); end
      total++; if (rd_addr !== {3'((m_rd + 1) % 5), 3'(m_rd)}) begin
        bad++; $display("FAIL rnd_addr c=%0d got=%b exp rd=%0d", c, rd_addr, m_rd); end
      total++; if (rd_ptr !== 3'(m_rd) || dout_valid !== m_valid) begin
        bad++; $display("FAIL rnd_state c=%0d got rd=%0d v=%b exp rd=%0d v=%b", c, rd_ptr, dout_valid, m_rd, m_valid); end
      if (m_valid) begin
        total++; if (dout_data !== m_data) begin
          bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, dout_data, m_data); end
      end
`ifdef FIFO_RD_STATS_EN
      total++; if (pop_count !== 16'(m_pop) || underrun !== 1'(dout_ready && !m_valid && m_occ() == 0)) begin
        bad++; $display("FAIL rnd_stats c=%0d got pop=%0d un=%b exp pop=%0d", c, pop_count, underrun, m_pop); end
`endif
      tick();
      if (init) begin
        init = 1'b0;
        wr_ptr = 3'd0;
      end
    end
    dout_ready = 1'b0;
    init = 1'b0;
  endtask

  task automatic test_async_reset();
    // Force the output stage full, then pull reset between clock edges.
    wr_ptr = 3'((m_rd + 3) % 5);
    tick();
    #2;
    rst = 1'b0;
    wr_ptr = 3'd0;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    wr_ptr = 3'd2;
    tick();
    total++; if (dout_valid !== 1'b1 || dout_data !== {mem[1], mem[0]} || rd_ptr !== 3'd2) begin
      bad++; $display("FAIL post_reset got v=%b d=%h rd=%0d exp v=1 d=%h rd=2", dout_valid, dout_data, rd_ptr, {mem[1], mem[0]}); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; init = 1'b0; wr_ptr = 3'd0; dout_ready = 1'b0;
    for (int k = 0; k < 5; k++) mem[k] = 4'(k + 8);
    #12;
    test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    test_fill();
    test_backpressure();
    test_wrap();
    test_drain();
    test_init_collision();
    m_rd = 0; m_valid = 1'b0; m_pop = 0;
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_read_port.md
Name: fifo_read_port

Overview:
- Read-side controller of the multi-word circular FIFO; the counterpart of the write-side pointer logic.
- Owns the read pointer and computes occupancy from the writer's pointer.
- Issues PAR_READ parallel read addresses to the register file and holds the fetched words in an output stage.
- Presents them downstream through a valid/ready handshake and exports rd_ptr so the writer can compute free space.

Parameters:
- NUM_BIT, 4, bits per FIFO word.
- NUM_REG, 4, usable FIFO depth in words; the ring has NUMP1 slots, one always kept empty.
- NUMP1, 5, ring size, must equal NUM_REG+1; all pointer arithmetic is mod NUMP1.
- PAR_READ, 2, words popped per handshake; 1 <= PAR_READ <= NUM_REG.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- init  in  1  synchronous clear, active-high.
- wr_ptr  in  PW  writer's pointer, PW = $clog2(NUM_REG)+1; value 0..NUMP1-1.
- rd_addr  out  PAR_READ*PW  slice i = (rd_ptr+i) mod NUMP1; combinational.
- mem_rdata  in  PAR_READ*NUM_BIT  combinational register-file data; slice i is the word at rd_addr slice i.
- rd_ptr  out  PW  read pointer, registered.
- occupancy  out  PW  (wr_ptr - rd_ptr) mod NUMP1, range 0..NUM_REG; combinational.
- empty  out  1  occupancy == 0.
- dout_valid  out  1  output stage holds PAR_READ words.
- dout_ready  in  1  downstream accept.
- dout_data  out  PAR_READ*NUM_BIT  slice i = word i; slice 0 is the oldest word.

Behaviour:
- Reset (rst low, asynchronous):
  - rd_ptr=0, dout_valid=0, dout_data=0, state EMPTY.
  - Reset takes effect immediately, including mid-transfer; data in flight is dropped.
- Occupancy: computed without wrap loss, i.e. if wr_ptr >= rd_ptr then wr_ptr-rd_ptr, else wr_ptr-rd_ptr+NUMP1, evaluated at PW+1 bits and truncated.
- Fetch condition: can_load = occupancy >= PAR_READ.
- FSM with two states:
  - EMPTY, dout_valid=0: if can_load, capture mem_rdata into dout_data, set rd_ptr <= (rd_ptr+PAR_READ) mod NUMP1, and go to FULL. Otherwise stay in EMPTY.
  - FULL, dout_valid=1: if dout_ready and can_load, reload back-to-back (capture, advance rd_ptr) and stay FULL, so throughput is 1 transfer per cycle. If dout_ready and !can_load, go to EMPTY; dout_data keeps its last value. If !dout_ready, dout_data and rd_ptr hold unchanged.
- Latency: the edge after wr_ptr makes occupancy >= PAR_READ, dout_valid=1 with the data. This is 1 cycle from the wr_ptr update.
- Ownership of popped words: rd_ptr advances at fetch, not at handshake. Words in the output stage are owned by this block, and their slots are free to the writer.
- Partial data: never presented. If occupancy < PAR_READ, the block waits, even for long periods.
- Wrap-around: address slices wrap independently; e.g. rd_ptr=4 with NUMP1=5 gives addresses 4 and 0.
- init=1 at an edge: rd_ptr=0, dout_valid=0, state EMPTY. init has priority over a handshake and a fetch in the same cycle. The handshake is not counted and the word is lost by design, since the writer is cleared with the same init.
- Illegal input: wr_ptr >= NUMP1 gives undefined occupancy. Under ASSERT only, flag it with $error.

Optional Feature:
- Macro: FIFO_RD_STATS_EN.
- When defined:
  - Adds output pop_count [15:0], the number of completed handshakes (dout_valid && dout_ready).
  - Cleared by reset or init; saturates at 16'hFFFF.
  - Adds output underrun [0:0], high for 1 cycle when dout_ready=1, dout_valid=0 and empty=1.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - Parameter defaults NUM_BIT, NUM_REG, NUMP1, PAR_READ.
  - Derived PW.
  - State encoding localparams ST_EMPTY=1'b0, ST_FULL=1'b1.
- One sub-module: ring_addr_add (combinational (a+b) mod NUMP1 on PW bits, with one extra internal bit). Instantiated PAR_READ times for rd_addr, plus once for the next rd_ptr.

Test Plan:
All scenarios use NUM_REG=4, NUMP1=5, PAR_READ=2, NUM_BIT=4; register file preloaded with mem[k]=k+8.
- Reset: rst=0 mid-run -> immediately rd_ptr=0, dout_valid=0, dout_data=0, empty=1, occupancy=0.
- Fill: wr_ptr=1 -> occupancy=1, dout_valid stays 0. Then wr_ptr=2 -> at the next edge dout_valid=1, dout_data={4'h9,4'h8}, rd_ptr=2, occupancy=0.
- Backpressure: dout_ready=0 for 3 cycles while wr_ptr goes to 4 -> dout_data held, rd_ptr=2. Then dout_ready=1 for 1 cycle -> next edge dout_data={4'hB,4'hA}, rd_ptr=4, dout_valid stays 1.
- Wrap: rd_ptr=4, wr_ptr=1 -> rd_addr={0,4}, occupancy=2. Fetch gives dout_data={mem[0],mem[4]}, rd_ptr=1.
- Drain to empty: FULL, dout_ready=1, occupancy=1 -> next edge dout_valid=0, rd_ptr unchanged.
- init collision: FULL with dout_ready=1, init=1, occupancy=2 -> next edge rd_ptr=0, dout_valid=0, no reload. With FIFO_RD_STATS_EN, pop_count is 0.
